dff_pipe: RTL and testbench
===========================

DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, 8, data width in bits; legal range 1..64.
REQ-002 Parameter DEPTH, 4, number of pipeline stages; legal range 1..32.
REQ-003 Parameter RST_VAL, {WIDTH{1'b0}}, value loaded into every data stage on reset.
REQ-004 Derived constant CW = $clog2(DEPTH+1), the occupancy count width.
REQ-005 The block SHALL have one clock and a synchronous, active-high reset.
REQ-006 i_clk  input  1  clock; all state changes on the rising edge.
REQ-007 i_rst  input  1  synchronous active-high reset.
REQ-008 i_en  input  1  shift enable; 0 = all stages hold.
REQ-009 i_flush  input  1  synchronous invalidate of all stages.
REQ-010 i_vld  input  1  qualifier for i_d.
REQ-011 i_d  input  WIDTH  input data.
REQ-012 o_q  output  WIDTH  last-stage data, registered.
REQ-013 o_vld  output  1  last-stage valid bit, registered.
REQ-014 o_cnt  output  CW  number of stages holding valid data, registered.
REQ-015 o_full  output  1  high when o_cnt == DEPTH.
REQ-016 o_empty  output  1  high when o_cnt == 0.

Function
REQ-017 Each stage k (0..DEPTH-1) SHALL hold a WIDTH-bit data register and a 1-bit valid register.
REQ-018 Edge with i_en=1, i_flush=0: stage0 <= {i_d, i_vld}; stage k <= stage k-1 for k >= 1.
REQ-019 Edge with i_en=0, i_flush=0: all data, valid and count registers SHALL hold.
REQ-020 o_q/o_vld SHALL equal stage DEPTH-1; latency i_d -> o_q = DEPTH enabled edges; disabled edges add no progress.
REQ-021 o_q SHALL NOT be gated by o_vld; invalid stages still present their data content.
REQ-022 Edge with i_flush=1: all valid bits and o_cnt SHALL clear to 0 regardless of i_en; i_vld of that edge discarded.
REQ-023 Edge with i_flush=1 and i_en=1: data registers SHALL still shift per REQ-018; only validity is cleared.
REQ-024 Edge with i_flush=1 and i_en=0: data registers SHALL hold.
REQ-025 o_cnt next = o_cnt + i_vld - o_vld on enabled non-flush edges; SHALL never exceed DEPTH nor underflow.
REQ-026 o_cnt SHALL always equal the population count of the stage valid bits.
REQ-027 o_full and o_empty SHALL be combinational decodes of o_cnt with no additional latency.
REQ-028 Full pipeline with i_en=1, i_vld=1: o_cnt SHALL stay at DEPTH (one in, one out).
REQ-029 DEPTH=1: stage0 is the output stage; o_cnt is 1 bit; all rules above apply unchanged.

Reset
REQ-030 Reset SHALL take priority over i_flush and i_en.
REQ-031 On an edge with i_rst=1: all data registers <= RST_VAL, all valid bits <= 0, o_cnt <= 0.
REQ-032 After reset: o_q = RST_VAL, o_vld = 0, o_cnt = 0, o_full = 0, o_empty = 1.
REQ-033 Reset asserted mid-stream SHALL discard all in-flight data; first edge after release behaves per REQ-018/019.
REQ-034 No output SHALL change in response to i_rst between clock edges.

Verification (WIDTH=8, DEPTH=4, RST_VAL=8'hA5)
REQ-035 Hold i_rst=1 for 4 cycles, release -> o_q=8'hA5, o_vld=0, o_cnt=0, o_empty=1 throughout.
REQ-036 i_en=1, i_vld=1, i_d=8'h01,02,03,04 on successive edges -> o_q=8'h01 with o_vld=1 after edge 4; o_cnt=1,2,3,4; o_full=1 after edge 4.
REQ-037 Same stream with i_en=0 on edge 2 only -> o_q=8'h01 appears after edge 5; o_cnt unchanged on edge 2.
REQ-038 Full pipeline, i_flush=1 with i_en=1, i_d=8'hFF, i_vld=1 -> next cycle o_cnt=0, o_vld=0, o_empty=1, stage0 data=8'hFF.
REQ-039 Full pipeline, i_vld alternating 1,0 with i_en=1 for 8 edges -> o_cnt tracks popcount every cycle, never >4; o_vld pattern = input pattern delayed 4 edges.
REQ-040 i_rst=1 asserted together with i_flush=1 and i_en=1 at o_cnt=3 -> next cycle all stages = 8'hA5, o_cnt=0, o_vld=0.

Source files
------------

// File: rtl/dff_pipe.sv
// Parameterised shift pipeline with per-stage valid bits, flush and an occupancy counter.
// Data always shifts on enable; flush clears validity only.
module dff_pipe #(
  parameter int               WIDTH   = 8,
  parameter int               DEPTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  localparam int              CW      = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_flush,
  input  logic             i_vld,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_vld,
  output logic [CW-1:0]    o_cnt,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // The count stays in range because it always equals the popcount of vld_q,
  // so modular CW-bit arithmetic is exact here.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    cnt_d  = cnt_q;
    if (i_en) begin
      data_d[0] = i_d;
      vld_d[0]  = i_vld;
      for (int k = 1; k < DEPTH; k++) begin
        data_d[k] = data_q[k-1];
        vld_d[k]  = vld_q[k-1];
      end
      cnt_d = cnt_q + CW'(i_vld) - CW'(vld_q[DEPTH-1]);
    end
    if (i_flush) begin
      vld_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= RST_VAL;
      end
      vld_q <= '0;
      cnt_q <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_q     = data_q[DEPTH-1];
  assign o_vld   = vld_q[DEPTH-1];
  assign o_cnt   = cnt_q;
  assign o_full  = (cnt_q == FULL_CNT);
  assign o_empty = (cnt_q == '0);

endmodule

// File: tb/tb_dff_pipe.sv
// Directed, table-driven bench for dff_pipe (WIDTH=8, DEPTH=4, RST_VAL=8'hA5)
// with a few hand-written multi-cycle sequences.
module tb_dff_pipe;

  typedef struct {
    string      name;
    logic       rst, en, flush, vld;
    logic [7:0] d;
    logic [7:0] q;
    logic       v;
    logic [2:0] cnt;
    logic       full, empty;
  } vec_t;

  logic       clock;
  logic       reset, en, flush, vld;
  logic [7:0] d;
  logic [7:0] q;
  logic       qVld;
  logic [2:0] cnt;
  logic       full, empty;

  int vectorsApplied = 0;
  int miscompares    = 0;
  vec_t vecs[$];

  dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hA5)) dut (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_en    (en),
    .i_flush (flush),
    .i_vld   (vld),
    .i_d     (d),
    .o_q     (q),
    .o_vld   (qVld),
    .o_cnt   (cnt),
    .o_full  (full),
    .o_empty (empty)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic vec_t mk(string n, logic r, logic e, logic f, logic iv, logic [7:0] id,
                              logic [7:0] eq, logic ev, logic [2:0] ec, logic ef, logic ee);
    vec_t t;
    t.name = n; t.rst = r; t.en = e; t.flush = f; t.vld = iv; t.d = id;
    t.q = eq; t.v = ev; t.cnt = ec; t.full = ef; t.empty = ee;
    return t;
  endfunction

  // Drive on the falling edge, let one rising edge happen, then settle 1ns.
  task automatic applyStimulus(input logic r, input logic e, input logic f,
                               input logic iv, input logic [7:0] id);
    @(negedge clock);
    reset = r; en = e; flush = f; vld = iv; d = id;
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string n, input logic [7:0] eq, input logic ev,
                             input logic [2:0] ec, input logic ef, input logic ee);
    vectorsApplied++;
    if ({q, qVld, cnt, full, empty} !== {eq, ev, ec, ef, ee}) begin
      miscompares++;
      $display("[TB] FAIL %s: got q=%h vld=%b cnt=%0d full=%b empty=%b, expected q=%h vld=%b cnt=%0d full=%b empty=%b",
               n, q, qVld, cnt, full, empty, eq, ev, ec, ef, ee);
    end
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; flush = 1'b0; vld = 1'b0; d = 8'h00;

    for (int i = 0; i < 4; i++)
      vecs.push_back(mk($sformatf("reset%0d", i), 1,0,0,0,8'h00, 8'hA5,0,0,0,1));
    vecs.push_back(mk("fill1",      0,1,0,1,8'h01, 8'hA5,0,1,0,0));
    vecs.push_back(mk("fill2",      0,1,0,1,8'h02, 8'hA5,0,2,0,0));
    vecs.push_back(mk("fill3",      0,1,0,1,8'h03, 8'hA5,0,3,0,0));
    vecs.push_back(mk("fill4",      0,1,0,1,8'h04, 8'h01,1,4,1,0));
    vecs.push_back(mk("oneInOut",   0,1,0,1,8'h05, 8'h02,1,4,1,0));
    vecs.push_back(mk("flushEn",    0,1,1,1,8'hFF, 8'h03,0,0,0,1));
    vecs.push_back(mk("drain1",     0,1,0,0,8'h10, 8'h04,0,0,0,1));
    vecs.push_back(mk("drain2",     0,1,0,0,8'h11, 8'h05,0,0,0,1));
    vecs.push_back(mk("drain3",     0,1,0,0,8'h12, 8'hFF,0,0,0,1));
    vecs.push_back(mk("flushHold",  0,0,1,1,8'h77, 8'hFF,0,0,0,1));
    vecs.push_back(mk("enHold",     0,0,0,1,8'h88, 8'hFF,0,0,0,1));
    vecs.push_back(mk("mid1",       0,1,0,1,8'h21, 8'h10,0,1,0,0));
    vecs.push_back(mk("mid2",       0,1,0,1,8'h22, 8'h11,0,2,0,0));
    vecs.push_back(mk("mid3",       0,1,0,1,8'h23, 8'h12,0,3,0,0));
    vecs.push_back(mk("rstFlushEn", 1,1,1,1,8'h33, 8'hA5,0,0,0,1));
    vecs.push_back(mk("postRst",    0,1,0,1,8'h44, 8'hA5,0,1,0,0));
    vecs.push_back(mk("reRst",      1,0,0,0,8'h00, 8'hA5,0,0,0,1));
    vecs.push_back(mk("gap1",       0,1,0,1,8'h01, 8'hA5,0,1,0,0));
    vecs.push_back(mk("gap2",       0,0,0,1,8'h02, 8'hA5,0,1,0,0));
    vecs.push_back(mk("gap3",       0,1,0,1,8'h02, 8'hA5,0,2,0,0));
    vecs.push_back(mk("gap4",       0,1,0,1,8'h03, 8'hA5,0,3,0,0));
    vecs.push_back(mk("gap5",       0,1,0,1,8'h04, 8'h01,1,4,1,0));
    vecs.push_back(mk("alt1",       0,1,0,1,8'h50, 8'h02,1,4,1,0));
    vecs.push_back(mk("alt2",       0,1,0,0,8'h51, 8'h03,1,3,0,0));
    vecs.push_back(mk("alt3",       0,1,0,1,8'h52, 8'h04,1,3,0,0));
    vecs.push_back(mk("alt4",       0,1,0,0,8'h53, 8'h50,1,2,0,0));
    vecs.push_back(mk("alt5",       0,1,0,1,8'h54, 8'h51,0,2,0,0));
    vecs.push_back(mk("alt6",       0,1,0,0,8'h55, 8'h52,1,2,0,0));
    vecs.push_back(mk("alt7",       0,1,0,1,8'h56, 8'h53,0,2,0,0));
    vecs.push_back(mk("alt8",       0,1,0,0,8'h57, 8'h54,1,2,0,0));

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].flush, vecs[i].vld, vecs[i].d);
      checkOutput(vecs[i].name, vecs[i].q, vecs[i].v, vecs[i].cnt, vecs[i].full, vecs[i].empty);
    end

    // Reset raised between edges must not disturb outputs until the next rising edge.
    @(negedge clock);
    reset = 1'b1; en = 1'b0; vld = 1'b0;
    #2;
    checkOutput("rstBetweenEdges", 8'h54, 1, 3'd2, 0, 0);
    @(posedge clock);
    #1;
    checkOutput("rstTakesEffect", 8'hA5, 0, 3'd0, 0, 1);

    for (int i = 0; i < 4; i++)
      applyStimulus(0, 1, 0, 1, 8'h60 + 8'(i));
    checkOutput("refill", 8'h60, 1, 3'd4, 1, 0);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 0, 0, 8'hEE);
      checkOutput($sformatf("fullHold%0d", i), 8'h60, 1, 3'd4, 1, 0);
    end
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 0, 0, 8'h70 + 8'(i));
      checkOutput($sformatf("empty%0d", i), (i < 3) ? 8'h61 + 8'(i) : 8'h70,
                  (i < 3), 3'(3 - i), 0, (i == 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
